// File: rtl/spi_frame_sender.sv
// rtl/spi_frame_sender.sv - decimating pixel FIFO serialised over multi-lane SPI
//
// Purpose: accepts one pixel in every 2^DECIM_LOG2 columns and rows, queues
// {pixel, eol, eof} in a word FIFO and shifts each word out MSB-first over
// LINES lanes with a generated data clock and an active-low chip select.
//
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   enable_in, pixel_valid_in      accept qualifiers
//   hcount_in, vcount_in, data_in  pixel position and value
//   chip_data_out/clk_out/sel_out  SPI pins (sel active low)
//   line_end_out, frame_end_out    one-cycle markers at chip select release
//   busy_out                       FIFO non-empty or word in progress
//   overflow_out, drop_count_out   sticky drop flag, saturating drop count
//   fifo_level_out                 FIFO occupancy

module spi_frame_sender #(
  parameter int DATA_WIDTH      = 8,
  parameter int LINES           = 4,
  parameter int DATA_CLK_PERIOD = 14,
  parameter int DECIM_LOG2      = 2,
  parameter int HCOUNT_WIDTH    = 10,
  parameter int VCOUNT_WIDTH    = 9,
  parameter int H_LAST          = 639,
  parameter int V_LAST          = 359,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0]       hcount_in,
  input  logic [VCOUNT_WIDTH-1:0]       vcount_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [LINES-1:0]              chip_data_out,
  output logic                          chip_clk_out,
  output logic                          chip_sel_out,
  output logic                          line_end_out,
  output logic                          frame_end_out,
  output logic                          busy_out,
  output logic                          overflow_out,
  output logic [15:0]                   drop_count_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int HALF  = DATA_CLK_PERIOD / 2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_WIDTH + 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(HALF + 1);

  localparam logic [HCOUNT_WIDTH-1:0] HMASK = HCOUNT_WIDTH'((1 << DECIM_LOG2) - 1);
  localparam logic [VCOUNT_WIDTH-1:0] VMASK = VCOUNT_WIDTH'((1 << DECIM_LOG2) - 1);
  localparam logic [HCOUNT_WIDTH-1:0] HSEL  = HCOUNT_WIDTH'(H_LAST) & ~HMASK;
  localparam logic [VCOUNT_WIDTH-1:0] VSEL  = VCOUNT_WIDTH'(V_LAST) & ~VMASK;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           overflow_q;
  logic [15:0]    drop_q;
  logic [EW-1:0]  rd_word;

  // Serialiser state
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  clk_q, clk_d;
  logic                  cs_q, cs_d;
  logic [LINES-1:0]      data_q, data_d;
  logic                  eol_q, eol_d, eof_q, eof_d;
  logic                  line_end_q, line_end_d, frame_end_q, frame_end_d;

  logic dec_ok, accept, full, push, pop, eol, eof;

  assign dec_ok = ((hcount_in & HMASK) == '0) && ((vcount_in & VMASK) == '0);
  assign accept = pixel_valid_in && enable_in && dec_ok;
  assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still takes a pixel when the FSM pops in the same cycle.
  assign push   = accept && (!full || pop);
  assign eol    = (hcount_in == HSEL);
  assign eof    = eol && (vcount_in == VSEL);
  assign rd_word = mem_q[rd_ptr_q];

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {data_in, eol, eof};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (accept && !push) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      beat_q      <= '0;
      phase_q     <= '0;
      clk_q       <= 1'b0;
      cs_q        <= 1'b1;
      data_q      <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      beat_q      <= beat_d;
      phase_q     <= phase_d;
      clk_q       <= clk_d;
      cs_q        <= cs_d;
      data_q      <= data_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    beat_d      = beat_q;
    phase_d     = phase_q;
    clk_d       = clk_q;
    cs_d        = cs_q;
    data_d      = data_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = rd_word[EW-1:2];
          data_d  = rd_word[EW-1 -: LINES];
          eol_d   = rd_word[1];
          eof_d   = rd_word[0];
          cs_d    = 1'b0;
          clk_d   = 1'b0;
          phase_d = '0;
          beat_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_q == PW'(HALF - 1)) begin
          phase_d = '0;
          clk_d   = ~clk_q;
          // clk_q high here means this toggle is a falling edge.
          if (clk_q) begin
            if (beat_q == BW'(BEATS - 1)) begin
              cs_d        = 1'b1;
              clk_d       = 1'b0;
              data_d      = '0;
              line_end_d  = eol_q;
              frame_end_d = eof_q;
              state_d     = GAP;
            end else begin
              beat_d  = beat_q + 1'b1;
              shreg_d = shreg_q << LINES;
              data_d  = shreg_d[DATA_WIDTH-1 -: LINES];
            end
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      GAP: begin
        if (phase_q == PW'(HALF - 1)) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign chip_data_out  = data_q;
  assign chip_clk_out   = clk_q;
  assign chip_sel_out   = cs_q;
  assign line_end_out   = line_end_q;
  assign frame_end_out  = frame_end_q;
  assign busy_out       = (count_q != '0) || (state_q != IDLE);
  assign overflow_out   = overflow_q;
  assign drop_count_out = drop_q;
  assign fifo_level_out = count_q;

endmodule

// File: tb/tb_spi_frame_sender.sv
// tb/tb_spi_frame_sender.sv - self-checking bench for spi_frame_sender

module tb_spi_frame_sender;

  localparam int DW = 8, LN = 4, PER = 14, DL = 2, HW = 10, VW = 9;
  localparam int HL = 639, VL = 359, FD = 16;
  localparam int HSEL_M = (HL >> DL) << DL;
  localparam int VSEL_M = (VL >> DL) << DL;
  localparam int STEP = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en, valid;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [DW-1:0] din;
  logic [LN-1:0] sd;
  logic          sck, scs, le, fe, busy, ovf;
  logic [15:0]   drops;
  logic [4:0]    level;

  logic          u1_valid;
  logic [HW-1:0] u1_hc;
  logic [VW-1:0] u1_vc;
  logic [DW-1:0] u1_din;
  logic [0:0]    u1_sd;
  logic          u1_sck, u1_scs, u1_le, u1_fe, u1_busy, u1_ovf;
  logic [15:0]   u1_drops;
  logic [4:0]    u1_level;

  spi_frame_sender #(.DATA_WIDTH(DW), .LINES(LN), .DATA_CLK_PERIOD(PER), .DECIM_LOG2(DL),
    .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .H_LAST(HL), .V_LAST(VL), .FIFO_DEPTH(FD)) u0 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .pixel_valid_in(valid),
    .hcount_in(hc), .vcount_in(vc), .data_in(din),
    .chip_data_out(sd), .chip_clk_out(sck), .chip_sel_out(scs),
    .line_end_out(le), .frame_end_out(fe), .busy_out(busy),
    .overflow_out(ovf), .drop_count_out(drops), .fifo_level_out(level));

  spi_frame_sender #(.DATA_WIDTH(DW), .LINES(1), .DATA_CLK_PERIOD(PER), .DECIM_LOG2(DL),
    .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .H_LAST(HL), .V_LAST(VL), .FIFO_DEPTH(FD)) u1 (
    .clk_in(clk), .rst_in(rst), .enable_in(1'b1), .pixel_valid_in(u1_valid),
    .hcount_in(u1_hc), .vcount_in(u1_vc), .data_in(u1_din),
    .chip_data_out(u1_sd), .chip_clk_out(u1_sck), .chip_sel_out(u1_scs),
    .line_end_out(u1_le), .frame_end_out(u1_fe), .busy_out(u1_busy),
    .overflow_out(u1_ovf), .drop_count_out(u1_drops), .fifo_level_out(u1_level));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Words as seen on the pins of u0, decoded at the protocol level.
  typedef struct {
    int   data;
    int   nb;
    int   len;
    logic le;
    logic fe;
  } rx_t;
  rx_t rx_q[$];
  int  stray = 0;

  initial begin
    logic prev_cs, prev_ck;
    int   acc, nb, len;
    prev_cs = 1'b1; prev_ck = 1'b0; acc = 0; nb = 0; len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs = 1'b1; prev_ck = 1'b0; acc = 0; nb = 0; len = 0;
      end else begin
        if (!scs) begin
          len++;
          if (sck && !prev_ck) begin
            acc = (acc << LN) | int'(sd);
            nb++;
          end
        end
        if (scs && !prev_cs) begin
          rx_q.push_back('{data: acc & 8'hFF, nb: nb, len: len, le: le, fe: fe});
          acc = 0; nb = 0; len = 0;
        end else if (le || fe) begin
          stray++;
        end
        prev_cs = scs;
        prev_ck = sck;
      end
    end
  end

  // Single-lane instance: record every beat value sampled on the rising edge.
  int u1_bits[$];
  int u1_len = 0;
  int u1_words = 0;
  initial begin
    logic pcs, pck;
    int   len;
    pcs = 1'b1; pck = 1'b0; len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!u1_scs) begin
          len++;
          if (u1_sck && !pck) u1_bits.push_back(int'(u1_sd));
        end
        if (u1_scs && !pcs) begin
          u1_len = len;
          u1_words++;
          len = 0;
        end
        pcs = u1_scs;
        pck = u1_sck;
      end
    end
  end

  task automatic drive_pixel(input int h, input int v, input int d);
    hc = HW'(h); vc = VW'(v); din = DW'(d); valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   h;
    int   v;
    int   d;
    bit   sent;
    logic eol;
    logic eof;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, outstanding, h, v, d, k;
    rx_t  exp_q[$];
    logic w_eol;

    vecs[0]  = '{0,      0,      8'hA5, 1, 0, 0};
    vecs[1]  = '{1,      0,      8'h11, 0, 0, 0};
    vecs[2]  = '{2,      0,      8'h22, 0, 0, 0};
    vecs[3]  = '{3,      0,      8'h33, 0, 0, 0};
    vecs[4]  = '{4,      1,      8'h44, 0, 0, 0};
    vecs[5]  = '{4,      4,      8'h3C, 1, 0, 0};
    vecs[6]  = '{HSEL_M, 0,      8'hC3, 1, 1, 0};
    vecs[7]  = '{HSEL_M, VSEL_M, 8'h7E, 1, 1, 1};
    vecs[8]  = '{HL,     VSEL_M, 8'h99, 0, 0, 0};
    vecs[9]  = '{0,      VSEL_M, 8'h0F, 1, 0, 0};
    vecs[10] = '{HSEL_M, 3,      8'hF0, 0, 0, 0};
    vecs[11] = '{HSEL_M - STEP, VSEL_M, 8'h5A, 1, 0, 0};

    en = 1'b1; valid = 1'b0; hc = '0; vc = '0; din = '0;
    u1_valid = 1'b0; u1_hc = '0; u1_vc = '0; u1_din = '0;
    rst = 1'b1;
    wait_cycles(3);
    check("rst_cs", scs, 1);
    check("rst_clk", sck, 0);
    check("rst_data", sd, 0);
    check("rst_le", le, 0);
    check("rst_fe", fe, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drops", drops, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    wait_cycles(2);
    check("idle_busy", busy, 0);

    // Table of single pixels: decimation, eol/eof thresholds, lane framing.
    for (int i = 0; i < 12; i++) begin
      base = rx_q.size();
      drive_pixel(vecs[i].h, vecs[i].v, vecs[i].d);
      wait_cycles(45);
      check($sformatf("vec%0d_sent", i), rx_q.size() - base, vecs[i].sent ? 1 : 0);
      if (vecs[i].sent && rx_q.size() > base) begin
        check($sformatf("vec%0d_data", i), rx_q[base].data, vecs[i].d);
        check($sformatf("vec%0d_eol", i), rx_q[base].le, vecs[i].eol);
        check($sformatf("vec%0d_eof", i), rx_q[base].fe, vecs[i].eof);
        check($sformatf("vec%0d_beats", i), rx_q[base].nb, DW / LN);
        check($sformatf("vec%0d_cslen", i), rx_q[base].len, (DW / LN) * PER);
      end
    end
    check("stray_pulses", stray, 0);
    check("table_drops", drops, 0);

    // Cycle-exact waveform of one word 0xA5 from the push edge onward.
    drive_pixel(0, 0, 8'hA5);
    for (int n = 1; n <= 32; n++) begin
      int t, e_cs, e_ck, e_d;
      t = n - 2;
      if (n < 2 || t >= 2 * PER) begin
        e_cs = 1; e_ck = 0; e_d = 0;
      end else begin
        e_cs = 0;
        e_ck = (t / (PER / 2)) % 2;
        e_d  = (t / PER == 0) ? 4'hA : 4'h5;
      end
      check($sformatf("wave%0d_cs", n), scs, e_cs);
      check($sformatf("wave%0d_clk", n), sck, e_ck);
      check($sformatf("wave%0d_data", n), sd, e_d);
      check($sformatf("wave%0d_le", n), le, 0);
      @(posedge clk); #1;
    end
    wait_cycles(10);

    // Randomised traffic against a queue model; throttled so the FIFO never fills.
    rx_q.delete();
    for (int c = 0; c < 2000; c++) begin
      outstanding = exp_q.size() - rx_q.size();
      if ($urandom_range(0, 9) == 0 && outstanding < 10) begin
        case ($urandom_range(0, 3))
          0:       h = 0;
          1:       h = HSEL_M;
          2:       h = $urandom_range(0, HL / STEP) * STEP;
          default: h = $urandom_range(0, HL);
        endcase
        case ($urandom_range(0, 3))
          0:       v = 0;
          1:       v = VSEL_M;
          2:       v = $urandom_range(0, VL / STEP) * STEP;
          default: v = $urandom_range(0, VL);
        endcase
        d  = $urandom_range(0, 255);
        en = ($urandom_range(0, 7) != 0);
        hc = HW'(h); vc = VW'(v); din = DW'(d); valid = 1'b1;
        if (en && (h % STEP == 0) && (v % STEP == 0)) begin
          w_eol = (h == HSEL_M);
          exp_q.push_back('{data: d, nb: DW / LN, len: (DW / LN) * PER,
                            le: w_eol, fe: w_eol && (v == VSEL_M)});
        end
      end else begin
        valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0; en = 1'b1;
    k = 0;
    while (rx_q.size() < exp_q.size() && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    wait_cycles(40);
    check("rand_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("rand%0d_data", i), rx_q[i].data, exp_q[i].data);
      check($sformatf("rand%0d_eol", i), rx_q[i].le, exp_q[i].le);
      check($sformatf("rand%0d_eof", i), rx_q[i].fe, exp_q[i].fe);
      check($sformatf("rand%0d_cslen", i), rx_q[i].len, exp_q[i].len);
    end
    check("rand_drops", drops, 0);
    check("rand_ovf", ovf, 0);

    // Burst of 20 back-to-back pixels into a 16-deep FIFO.
    base = rx_q.size();
    for (int i = 0; i < 20; i++) begin
      hc = '0; vc = '0; din = DW'(i); valid = 1'b1;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("burst_level", level, FD);
    check("burst_drops", drops, 3);
    check("burst_ovf", ovf, 1);
    k = 0;
    while (rx_q.size() < base + 17 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    wait_cycles(60);
    check("burst_count", rx_q.size() - base, 17);
    for (int i = 0; i < 17 && base + i < rx_q.size(); i++) begin
      check($sformatf("burst%0d_data", i), rx_q[base + i].data, i);
    end
    drive_pixel(0, 0, 8'h01);
    wait_cycles(45);
    check("ovf_sticky", ovf, 1);
    check("drops_hold", drops, 3);

    // Asynchronous reset mid-word with five words still queued.
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      hc = '0; vc = '0; din = DW'(8'h40 + i); valid = 1'b1;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_cycles(10);
    check("pre_rst_level", level, 5);
    check("pre_rst_cs", scs, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cs", scs, 1);
    check("arst_clk", sck, 0);
    check("arst_data", sd, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_drops", drops, 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    check("arst_no_word", rx_q.size() - base, 0);
    drive_pixel(0, 0, 8'h5A);
    wait_cycles(45);
    check("post_rst_count", rx_q.size() - base, 1);
    if (rx_q.size() > base) begin
      check("post_rst_data", rx_q[base].data, 8'h5A);
      check("post_rst_cslen", rx_q[base].len, (DW / LN) * PER);
    end
    check("post_rst_level", level, 0);

    // Single-lane instance: eight beats of 0x81, MSB first.
    u1_din = 8'h81; u1_valid = 1'b1;
    @(posedge clk); #1;
    u1_valid = 1'b0;
    wait_cycles(130);
    check("l1_words", u1_words, 1);
    check("l1_beats", u1_bits.size(), 8);
    for (int b = 0; b < 8 && b < u1_bits.size(); b++) begin
      check($sformatf("l1_beat%0d", b), u1_bits[b], (8'h81 >> (7 - b)) & 1);
    end
    check("l1_cslen", u1_len, 8 * PER);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_sender.md
Name: spi_frame_sender

Overview:
Parametrised successor to the single-word multi-lane SPI sender. It takes the reconstructed camera pixel stream and decimates it by 2^DECIM_LOG2 in both axes. Accepted pixels are buffered in an internal FIFO, then serialised over LINES parallel data lanes with a generated data clock and an active-low chip select. It also emits line-end and frame-end markers, a sticky overflow flag and a drop counter. It sits between luminance_reconstruct and the SPI pins in the clk_camera domain.

Parameters:
DATA_WIDTH, 8, pixel bits per word; must be a multiple of LINES.
LINES, 4, parallel data lanes.
DATA_CLK_PERIOD, 14, clk_in cycles per chip_clk_out period; even, at least 4.
DECIM_LOG2, 2, decimation shift; a pixel is accepted when the low DECIM_LOG2 bits of hcount and vcount are both 0.
HCOUNT_WIDTH, 10, hcount width.
VCOUNT_WIDTH, 9, vcount width.
H_LAST, 639, last camera column.
V_LAST, 359, last camera row.
FIFO_DEPTH, 16, word FIFO depth; must be a power of 2.

Ports:
clk_in  in  1  system clock (clk_camera)
rst_in  in  1  reset; asynchronous and active-high
enable_in  in  1  allows new pixels to be accepted
pixel_valid_in  in  1  input pixel strobe
hcount_in  in  HCOUNT_WIDTH  pixel column
vcount_in  in  VCOUNT_WIDTH  pixel row
data_in  in  DATA_WIDTH  pixel value
chip_data_out  out  LINES  serial lanes
chip_clk_out  out  1  data clock
chip_sel_out  out  1  chip select, active low
line_end_out  out  1  one-cycle pulse at the end of the last word of a decimated line
frame_end_out  out  1  one-cycle pulse at the end of the last word of a frame
busy_out  out  1  high when the FIFO is non-empty or the FSM is not in IDLE
overflow_out  out  1  sticky flag: a pixel was dropped
drop_count_out  out  16  saturating count of dropped pixels
fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (asynchronous): chip_sel_out=1, chip_clk_out=0, chip_data_out=0, line_end_out=0, frame_end_out=0, overflow_out=0, drop_count_out=0. The FIFO is emptied and the FSM returns to IDLE. Reset asserted mid-word aborts that word immediately.
- Accept condition: pixel_valid_in && enable_in && low bits of hcount_in and vcount_in equal to 0.
- Last-column and last-row thresholds:
  - HSEL = H_LAST with the low DECIM_LOG2 bits cleared (636 at defaults).
  - VSEL = V_LAST with the low DECIM_LOG2 bits cleared (356 at defaults).
- Each accepted pixel pushes {data_in, eol=(hcount_in==HSEL), eof=eol&&(vcount_in==VSEL)} into the FIFO.
- Push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
- On a failed push: overflow_out is set; drop_count_out increments and saturates at 0xFFFF. Dropped pixels are never sent.
- Words leave in FIFO order. BEATS = DATA_WIDTH/LINES. HALF = DATA_CLK_PERIOD/2.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to SHIFT. Next cycle: chip_sel_out=0, chip_clk_out=0, chip_data_out = top LINES bits of the word, MSB on lane LINES-1.
  - SHIFT: chip_clk_out toggles every HALF cycles, starting low. Data is stable while the clock is high. On each falling edge the register shifts left by LINES and the next beat is presented. After the BEATS-th falling edge: chip_sel_out=1, chip_data_out=0, go to GAP.
  - GAP: lasts HALF cycles. On the first GAP cycle, line_end_out pulses if eol and frame_end_out pulses if eof (one cycle each). Then go to IDLE.
- Timing:
  - Latency from accept (FIFO empty, FSM idle) to chip_sel_out low: 2 cycles.
  - chip_sel_out stays low for BEATS*DATA_CLK_PERIOD cycles (28 at defaults).
- enable_in low stops accepts only: the word in flight completes and the FIFO drains.
- Changing enable_in mid-word has no effect on that word.
- fifo_level_out updates on the cycle after each push or pop.

Test Plan:
- Single pixel (0,0), data 0xA5, defaults → chip_sel_out low 2 cycles later; lanes show 0xA then 0x5; two rising edges 14 cycles apart; chip_sel_out high after 28 cycles; no end pulses.
- Valid pixels at hcount 1, 2, 3 with vcount 0, then at (4,1) and (4,4) → only (4,4) is transmitted; drop_count_out stays 0.
- Pixel at (636,0), then pixel at (636,356) → first word gives line_end_out only; second word gives line_end_out and frame_end_out; each is a single-cycle pulse at the chip_sel_out rise.
- Burst of 20 accepted pixels on consecutive cycles, data 0..19 → 17 words sent in order 0..16; drop_count_out=3; overflow_out=1 and stays 1 until reset.
- Assert rst_in mid-SHIFT with the FIFO holding 5 words → outputs return to reset values asynchronously with no clock edge; fifo_level_out=0; after release, a new pixel transmits normally.
- LINES=1, DATA_WIDTH=8, data 0x81 → 8 beats on lane 0: 1,0,0,0,0,0,0,1; chip_sel_out low for 112 cycles.
